ram_arb: RTL and testbench
==========================

# ram_arb

Two-requester arbiter that shares the unified RAM between the instruction-fetch unit and the load/store unit through a single access slot per cycle. It drives only the RAM's data-read and data-write ports; the RAM's instruction-read port is held disabled. Each requester has a valid/ready request channel and a registered one-cycle response. Out-of-range addresses are blocked from the RAM and flagged with an error response.

## Interface
- DATA_WIDTH, default `DATA_WIDTH: RAM word width, either 32 or 64.
- ADDR_WIDTH, default `ADDR_WIDTH: byte-address width.
- RAM_DEPTH, default 2**14: number of RAM words, used for the range check.

- i_sys_clk  in  1  clock. One clock domain; all logic on the rising edge.
- i_sys_rst_n  in  1  reset. Asynchronous assertion, active-low.
- i_arb_inst_req_valid  in  1  fetch request.
- o_arb_inst_req_ready  out  1  fetch request accepted this cycle.
- i_arb_inst_req_addr  in  ADDR_WIDTH  fetch byte address.
- o_arb_inst_resp_valid  out  1  fetch response strobe, one cycle wide.
- o_arb_inst_resp_data  out  DATA_WIDTH  full RAM word.
- o_arb_inst_resp_err  out  1  fetch address out of range.
- i_arb_data_req_valid  in  1  load/store request.
- o_arb_data_req_ready  out  1  load/store request accepted.
- i_arb_data_req_we  in  1  1 = store, 0 = load.
- i_arb_data_req_addr  in  ADDR_WIDTH  load/store byte address.
- i_arb_data_req_wdata  in  DATA_WIDTH  store data.
- i_arb_data_req_mask  in  DATA_WIDTH/8  store byte mask.
- o_arb_data_resp_valid  out  1  load/store response strobe, one cycle wide.
- o_arb_data_resp_data  out  DATA_WIDTH  load data; 0 for stores.
- o_arb_data_resp_err  out  1  load/store address out of range.
- o_ram_rd_inst_en  out  1  RAM instruction-read enable; tied 0.
- o_ram_rd_data_en, o_ram_rd_data_addr  out  1 / ADDR_WIDTH  RAM read port.
- i_ram_rd_data_data  in  DATA_WIDTH  combinational RAM read data.
- o_ram_wr_data_en, o_ram_wr_data_addr, o_ram_wr_data_data, o_ram_wr_data_mask  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  RAM write port.

## Operation
- **Grant (combinational, one per cycle):**
  - If only one requester is valid, it is granted.
  - If both are valid, the winner is chosen by the policy in Configuration.
  - The ready output of the granted requester equals its valid; the loser's ready is 0.
- **Requester rule:** address, we, wdata and mask must stay stable while valid is high and ready is low. Dropping valid before acceptance is permitted.
- **Range check:** an address is in range when `ADDR_INIT <= addr < `ADDR_INIT + RAM_DEPTH*(DATA_WIDTH/8).
- **In-range grant:**
  - Fetch or load: o_ram_rd_data_en=1 and the address is forwarded.
  - Store: o_ram_wr_data_en=1 with address, data and mask forwarded.
- **Out-of-range grant:** no RAM enable is asserted. The slot is still consumed and the response carries err=1 and data=0.
- **Address low bits:** below word alignment they are passed through unchanged; the RAM drops them.
- **Idle cycles:** all RAM enables are 0 and the RAM address/data outputs are 0.
- **Response registers, loaded on every accept:**
  - resp_valid ← 1.
  - resp_data ← i_ram_rd_data_data for reads, 0 for stores and errors.
  - resp_err ← range fail.
  - Cycles with no accept clear resp_valid; data and err hold their last value.

## Timing
- A request accepted in cycle N:
  - drives the RAM combinationally in cycle N;
  - a store commits at the rising edge ending cycle N;
  - resp_valid is high for exactly cycle N+1.
- Throughput: one access per cycle in total.
- A store in cycle N followed by a read of the same word in cycle N+1 returns the new data.
- Reset values: all resp_valid/resp_data/resp_err outputs are 0 and the round-robin pointer is "data last".
- Ready outputs are 0 while reset is asserted.
- Reset asserted mid-operation drops any pending response.

## Configuration
- RAM_ARB_RR_EN defined:
  - Round-robin arbitration using a 1-bit last-grant register, updated on every accept.
  - On a tie, the requester not granted last wins; the first tie after reset goes to fetch.
- RAM_ARB_RR_EN undefined:
  - Fixed priority, data requester always wins ties.
  - The pointer register is not built.

## Test plan
- Reset, no requests -> all resp_* = 0, RAM enables = 0, readies = 0 during reset and 0 afterwards with valids low.
- Store addr=`ADDR_INIT+8, wdata=0xA5A5_0000, mask=4'b1100, then load same address next cycle -> data_resp_valid pulses in both following cycles; load returns upper half 0xA5A5 merged with prior lower half, err=0.
- Both valid for 4 cycles with RAM_ARB_RR_EN -> grants F,D,F,D and each response arrives one cycle after its grant; without the macro -> D,D,D,D with inst ready stuck at 0.
- Fetch addr=`ADDR_INIT-4 -> o_ram_rd_data_en stays 0; next cycle inst_resp_valid=1, err=1, data=0.
- Store to the first address past the end -> o_ram_wr_data_en stays 0, data_resp_err=1, and RAM contents are unchanged on readback.
- Reset asserted in the cycle after a load accept -> data_resp_valid is forced to 0 immediately and no response appears after reset release.

Source files
------------

// File: rtl/ram_arb.sv
// ram_arb: two-requester arbiter sharing the unified RAM between the
// instruction-fetch unit and the load/store unit.
//
// The RAM is reached through its data-read and data-write ports only.
// The instruction-read port stays disabled. One access slot is granted
// per cycle. Each requester gets a registered one-cycle response.
// Addresses outside the RAM window never reach the RAM. They come back
// with err=1 and data=0.
//
// Optional feature: define RAM_ARB_RR_EN for round-robin tie breaking.
// Without it, the data requester always wins a tie and no pointer
// register is built.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif

module ram_arb #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int RAM_DEPTH  = 2**14
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,

    // instruction-fetch requester
    input  logic                    i_arb_inst_req_valid,
    output logic                    o_arb_inst_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_arb_inst_req_addr,
    output logic                    o_arb_inst_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_arb_inst_resp_data,
    output logic                    o_arb_inst_resp_err,

    // load/store requester
    input  logic                    i_arb_data_req_valid,
    output logic                    o_arb_data_req_ready,
    input  logic                    i_arb_data_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_arb_data_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_arb_data_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_arb_data_req_mask,
    output logic                    o_arb_data_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_arb_data_resp_data,
    output logic                    o_arb_data_resp_err,

    // RAM ports
    output logic                    o_ram_rd_inst_en,
    output logic                    o_ram_rd_data_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_data_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data_data,
    output logic                    o_ram_wr_data_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_wr_data_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_wr_data_mask
);

    localparam int MASK_W = DATA_WIDTH / 8;

    // The window bounds carry one extra bit, so the end address cannot
    // wrap when the RAM sits at the top of the address space.
    localparam logic [ADDR_WIDTH:0] ADDR_LO = (ADDR_WIDTH+1)'(`ADDR_INIT);
    localparam logic [ADDR_WIDTH:0] ADDR_HI = ADDR_LO + (ADDR_WIDTH+1)'(RAM_DEPTH * MASK_W);

    logic                  grant_inst;
    logic                  grant_data;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic                  in_range;
    logic                  rd_en;
    logic                  wr_en;

`ifdef RAM_ARB_RR_EN
    // 1 = data requester was granted last; a tie goes to the other side
    logic                  last_data;
`endif

    // Grant one requester per cycle; nothing is granted while in reset
    always_comb begin
        // NOTE: combinational blocks use blocking '=' with a default for every output first, so no latch can be inferred
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (i_sys_rst_n) begin
            if (i_arb_inst_req_valid && i_arb_data_req_valid) begin
`ifdef RAM_ARB_RR_EN
                if (last_data) begin
                    grant_inst = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
`else
                grant_data = 1'b1;
`endif
            end else begin
                grant_inst = i_arb_inst_req_valid;
                grant_data = i_arb_data_req_valid;
            end
        end
    end

    // Grants are only raised alongside valid, so a grant is the accept itself
    assign o_arb_inst_req_ready = grant_inst;
    assign o_arb_data_req_ready = grant_data;
    assign grant_any            = grant_inst | grant_data;

    // Select the granted request and check it against the RAM window
    always_comb begin
        sel_addr = grant_inst ? i_arb_inst_req_addr : i_arb_data_req_addr;
        sel_we   = grant_data & i_arb_data_req_we;
        in_range = ({1'b0, sel_addr} >= ADDR_LO) && ({1'b0, sel_addr} < ADDR_HI);
        rd_en    = grant_any & in_range & ~sel_we;
        wr_en    = grant_any & in_range & sel_we;
    end

    // Drive the RAM; every port field is zero when its enable is low
    always_comb begin
        o_ram_rd_inst_en   = 1'b0;
        o_ram_rd_data_en   = rd_en;
        o_ram_rd_data_addr = rd_en ? sel_addr : '0;
        o_ram_wr_data_en   = wr_en;
        o_ram_wr_data_addr = wr_en ? sel_addr : '0;
        o_ram_wr_data_data = wr_en ? i_arb_data_req_wdata : '0;
        o_ram_wr_data_mask = wr_en ? i_arb_data_req_mask : '0;
    end

    // Register the one-cycle responses; data and err hold between accepts
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            // NOTE: sequential state uses non-blocking '<=' and every register here has a reset value
            o_arb_inst_resp_valid <= 1'b0;
            o_arb_inst_resp_data  <= '0;
            o_arb_inst_resp_err   <= 1'b0;
            o_arb_data_resp_valid <= 1'b0;
            o_arb_data_resp_data  <= '0;
            o_arb_data_resp_err   <= 1'b0;
        end else begin
            o_arb_inst_resp_valid <= grant_inst;
            o_arb_data_resp_valid <= grant_data;
            if (grant_inst) begin
                o_arb_inst_resp_data <= rd_en ? i_ram_rd_data_data : '0;
                o_arb_inst_resp_err  <= ~in_range;
            end
            if (grant_data) begin
                // rd_en is already low for stores and out-of-range accesses
                o_arb_data_resp_data <= rd_en ? i_ram_rd_data_data : '0;
                o_arb_data_resp_err  <= ~in_range;
            end
        end
    end

`ifdef RAM_ARB_RR_EN
    // Remember who took the last slot; starting at "data last" makes the first tie go to fetch
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            last_data <= 1'b1;
        end else if (grant_any) begin
            last_data <= grant_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed, table-driven bench for ram_arb with a behavioural
// RAM (combinational read, masked write on the rising edge).

`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif

module tb_ram_arb;

    localparam logic [31:0] A = `ADDR_INIT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, dv, we;
    logic [31:0] ia, da, wd;
    logic [3:0]  m;

    logic        ir, dr, irv, ire, drv, dre;
    logic [31:0] ird, drd;
    logic        rd_inst_en, rd_en, wr_en;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
    logic [3:0]  wr_mask;

    int checks   = 0;
    int failures = 0;

    logic        preload = 1'b0;
    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(16384)) dut (
        .i_sys_clk             (clk),
        .i_sys_rst_n           (rst_n),
        .i_arb_inst_req_valid  (iv),
        .o_arb_inst_req_ready  (ir),
        .i_arb_inst_req_addr   (ia),
        .o_arb_inst_resp_valid (irv),
        .o_arb_inst_resp_data  (ird),
        .o_arb_inst_resp_err   (ire),
        .i_arb_data_req_valid  (dv),
        .o_arb_data_req_ready  (dr),
        .i_arb_data_req_we     (we),
        .i_arb_data_req_addr   (da),
        .i_arb_data_req_wdata  (wd),
        .i_arb_data_req_mask   (m),
        .o_arb_data_resp_valid (drv),
        .o_arb_data_resp_data  (drd),
        .o_arb_data_resp_err   (dre),
        .o_ram_rd_inst_en      (rd_inst_en),
        .o_ram_rd_data_en      (rd_en),
        .o_ram_rd_data_addr    (rd_addr),
        .i_ram_rd_data_data    (rd_data),
        .o_ram_wr_data_en      (wr_en),
        .o_ram_wr_data_addr    (wr_addr),
        .o_ram_wr_data_data    (wr_data),
        .o_ram_wr_data_mask    (wr_mask)
    );

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - A;
        return int'(off[15:2]);
    endfunction

    // Behavioural RAM: idle read data is a marker that must never leak into a response
    always_comb rd_data = rd_en ? mem[widx(rd_addr)] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (preload) begin
            mem[0]     <= 32'h7777_8888;
            mem[2]     <= 32'h1111_2222;
            mem[4]     <= 32'h3333_4444;
            mem[16383] <= 32'h5555_6666;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) mem[widx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        we;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  m;
        logic        x_ir;
        logic        x_dr;
        logic        x_rd_en;
        logic [31:0] x_rd_addr;
        logic        x_wr_en;
        logic [31:0] x_wr_addr;
        logic [31:0] x_wr_data;
        logic [3:0]  x_wr_mask;
        logic        x_irv;
        logic [31:0] x_ird;
        logic        x_ire;
        logic        x_drv;
        logic [31:0] x_drd;
        logic        x_dre;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        //           name       iv  ia             dv  we  da              wd             m        ir  dr  rde rd_addr     wre wr_addr  wr_data        wr_m     irv ird            ire drv drd            dre
        vecs[0] = '{"idle",    0, 32'h0,         0, 0, 32'h0,          32'h0,         4'h0,    0, 0, 0, 32'h0,      0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         0, 0, 32'h0,         0};
        vecs[1] = '{"st_a8",   0, 32'h0,         1, 1, A+32'h8,        32'hA5A5_0000, 4'b1100, 0, 1, 0, 32'h0,      1, A+32'h8, 32'hA5A5_0000, 4'b1100, 0, 32'h0,         0, 1, 32'h0,         0};
        vecs[2] = '{"ld_a8",   0, 32'h0,         1, 0, A+32'h8,        32'h0,         4'h0,    0, 1, 1, A+32'h8,    0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         0, 1, 32'hA5A5_2222, 0};
        vecs[3] = '{"if_a10",  1, A+32'h10,      0, 0, 32'h0,          32'h0,         4'h0,    1, 0, 1, A+32'h10,   0, 32'h0,   32'h0,         4'h0,    1, 32'h3333_4444, 0, 0, 32'hA5A5_2222, 0};
        vecs[4] = '{"if_lo",   1, A-32'h4,       0, 0, 32'h0,          32'h0,         4'h0,    1, 0, 0, 32'h0,      0, 32'h0,   32'h0,         4'h0,    1, 32'h0,         1, 0, 32'hA5A5_2222, 0};
        vecs[5] = '{"st_end",  0, 32'h0,         1, 1, A+32'h1_0000,   32'hFFFF_FFFF, 4'hF,    0, 1, 0, 32'h0,      0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         1, 1, 32'h0,         1};
        vecs[6] = '{"ld_last", 0, 32'h0,         1, 0, A+32'hFFFE,     32'h0,         4'h0,    0, 1, 1, A+32'hFFFE, 0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         1, 1, 32'h5555_6666, 0};
        vecs[7] = '{"ld_a0",   0, 32'h0,         1, 0, A,              32'h0,         4'h0,    0, 1, 1, A,          0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         1, 1, 32'h7777_8888, 0};
        vecs[8] = '{"idle2",   0, A+32'h10,      0, 1, A+32'h8,        32'h1234,      4'hF,    0, 0, 0, 32'h0,      0, 32'h0,   32'h0,         4'h0,    0, 32'h0,         1, 0, 32'h7777_8888, 0};
        vecs[9] = '{"if_a0",   1, A,             0, 0, 32'h0,          32'h0,         4'h0,    1, 0, 1, A,          0, 32'h0,   32'h0,         4'h0,    1, 32'h7777_8888, 0, 0, 32'h7777_8888, 0};

        // Reset with both requesters asserting: nothing may be accepted
        rst_n = 1'b0; preload = 1'b1;
        iv = 1'b1; ia = A; dv = 1'b1; we = 1'b1; da = A + 32'h8; wd = 32'hFFFF_FFFF; m = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ir", {31'b0, ir}, 32'd0);
        check("rst.dr", {31'b0, dr}, 32'd0);
        check("rst.rd_en", {31'b0, rd_en}, 32'd0);
        check("rst.wr_en", {31'b0, wr_en}, 32'd0);
        check("rst.rd_inst_en", {31'b0, rd_inst_en}, 32'd0);
        check("rst.irv", {31'b0, irv}, 32'd0);
        check("rst.drv", {31'b0, drv}, 32'd0);
        check("rst.ird", ird, 32'd0);
        check("rst.drd", drd, 32'd0);
        check("rst.ire", {31'b0, ire}, 32'd0);
        check("rst.dre", {31'b0, dre}, 32'd0);
        preload = 1'b0;
        @(negedge clk);
        iv = 1'b0; dv = 1'b0; we = 1'b0; ia = '0; da = '0; wd = '0; m = '0;
        rst_n = 1'b1;

        // Table-driven single-requester vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            iv = vecs[i].iv; ia = vecs[i].ia; dv = vecs[i].dv; we = vecs[i].we;
            da = vecs[i].da; wd = vecs[i].wd; m = vecs[i].m;
            #1;
            check($sformatf("%s.ir", vecs[i].name), {31'b0, ir}, {31'b0, vecs[i].x_ir});
            check($sformatf("%s.dr", vecs[i].name), {31'b0, dr}, {31'b0, vecs[i].x_dr});
            check($sformatf("%s.rd_en", vecs[i].name), {31'b0, rd_en}, {31'b0, vecs[i].x_rd_en});
            check($sformatf("%s.rd_addr", vecs[i].name), rd_addr, vecs[i].x_rd_addr);
            check($sformatf("%s.wr_en", vecs[i].name), {31'b0, wr_en}, {31'b0, vecs[i].x_wr_en});
            check($sformatf("%s.wr_addr", vecs[i].name), wr_addr, vecs[i].x_wr_addr);
            check($sformatf("%s.wr_data", vecs[i].name), wr_data, vecs[i].x_wr_data);
            check($sformatf("%s.wr_mask", vecs[i].name), {28'b0, wr_mask}, {28'b0, vecs[i].x_wr_mask});
            check($sformatf("%s.rd_inst_en", vecs[i].name), {31'b0, rd_inst_en}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("%s.irv", vecs[i].name), {31'b0, irv}, {31'b0, vecs[i].x_irv});
            check($sformatf("%s.ird", vecs[i].name), ird, vecs[i].x_ird);
            check($sformatf("%s.ire", vecs[i].name), {31'b0, ire}, {31'b0, vecs[i].x_ire});
            check($sformatf("%s.drv", vecs[i].name), {31'b0, drv}, {31'b0, vecs[i].x_drv});
            check($sformatf("%s.drd", vecs[i].name), drd, vecs[i].x_drd);
            check($sformatf("%s.dre", vecs[i].name), {31'b0, dre}, {31'b0, vecs[i].x_dre});
        end

        // Fresh reset so the tie sequence starts from the reset pointer
        @(negedge clk);
        iv = 1'b0; dv = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // Both requesters valid for four cycles
        for (int k = 0; k < 4; k++) begin
            logic fw;
`ifdef RAM_ARB_RR_EN
            fw = (k % 2 == 0);
`else
            fw = 1'b0;
`endif
            @(negedge clk);
            iv = 1'b1; ia = A + 32'h10; dv = 1'b1; we = 1'b0; da = A + 32'h8;
            #1;
            check($sformatf("tie%0d.ir", k), {31'b0, ir}, {31'b0, fw});
            check($sformatf("tie%0d.dr", k), {31'b0, dr}, {31'b0, ~fw});
            check($sformatf("tie%0d.rd_addr", k), rd_addr, fw ? A + 32'h10 : A + 32'h8);
            @(posedge clk);
            #1;
            check($sformatf("tie%0d.irv", k), {31'b0, irv}, {31'b0, fw});
            check($sformatf("tie%0d.drv", k), {31'b0, drv}, {31'b0, ~fw});
            if (fw) check($sformatf("tie%0d.ird", k), ird, 32'h3333_4444);
            else    check($sformatf("tie%0d.drd", k), drd, 32'hA5A5_2222);
        end
        @(negedge clk);
        iv = 1'b0; dv = 1'b0;

        // Reset in the cycle after a load accept drops the pending response
        @(negedge clk);
        dv = 1'b1; we = 1'b0; da = A + 32'h8;
        @(posedge clk);
        #1;
        check("mid.drv_before", {31'b0, drv}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.drv_in_reset", {31'b0, drv}, 32'd0);
        check("mid.dr_in_reset", {31'b0, dr}, 32'd0);
        check("mid.rd_en_in_reset", {31'b0, rd_en}, 32'd0);
        @(negedge clk);
        dv = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid.after%0d.drv", k), {31'b0, drv}, 32'd0);
            check($sformatf("mid.after%0d.drd", k), drd, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
